// File: rtl/reg_file_sb.sv
// Multi-read-port register file with a per-register pending-write scoreboard.
// Reads are combinational; an optional bypass forwards same-cycle writeback data.
module reg_file_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  localparam int DEPTH   = 2**ADDR_W
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [NUM_RD*ADDR_W-1:0] i_rd_addr,
  output logic [NUM_RD*DATA_W-1:0] o_rd_data,
  output logic [NUM_RD-1:0]        o_rd_busy,
  input  logic                     i_wr_en,
  input  logic [ADDR_W-1:0]        i_wr_addr,
  input  logic [DATA_W-1:0]        i_wr_data,
  input  logic                     i_rsv_en,
  input  logic [ADDR_W-1:0]        i_rsv_addr,
  output logic [DEPTH-1:0]         o_pending
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0]  r_pending;

  logic w_wr_eff;
  logic w_rsv_eff;

  // Accesses to a hardwired-zero register are discarded before touching state.
  assign w_wr_eff  = i_wr_en  && !i_rst && !((ZERO_REG != 0) && (i_wr_addr  == '0));
  assign w_rsv_eff = i_rsv_en && !i_rst && !((ZERO_REG != 0) && (i_rsv_addr == '0));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_pending <= '0;
    end else begin
      if (w_wr_eff) begin
        r_mem[i_wr_addr]     <= i_wr_data;
        r_pending[i_wr_addr] <= 1'b0;
      end
      // Applied after the writeback so a same-address reserve (newer instruction) wins.
      if (w_rsv_eff) begin
        r_pending[i_rsv_addr] <= 1'b1;
      end
    end
  end

  assign o_pending = r_pending;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
      logic [ADDR_W-1:0] w_addr;
      logic              w_hit;
      logic              w_zero;

      assign w_addr = i_rd_addr[gi*ADDR_W +: ADDR_W];
      assign w_zero = (ZERO_REG != 0) && (w_addr == '0);
      assign w_hit  = (BYPASS != 0) && w_wr_eff && (i_wr_addr == w_addr);

      assign o_rd_data[gi*DATA_W +: DATA_W] = w_zero ? '0 :
                                              w_hit  ? i_wr_data : r_mem[w_addr];
      assign o_rd_busy[gi] = !w_zero && !w_hit && r_pending[w_addr];
    end
  endgenerate

endmodule

// File: tb/tb_reg_file_sb.sv
// Scoreboard bench for reg_file_sb: one bypassing and one non-bypassing instance
// share the same stimulus; expected read results are queued and checked at negedge.
module tb_reg_file_sb;

  logic        clk = 1'b0;
  logic        i_rst = 1'b0;
  logic        i_wr_en = 1'b0;
  logic [4:0]  i_wr_addr = '0;
  logic [31:0] i_wr_data = '0;
  logic        i_rsv_en = 1'b0;
  logic [4:0]  i_rsv_addr = '0;
  logic [4:0]  a0 = '0;
  logic [4:0]  a1 = '0;
  logic [9:0]  rd_addr;

  logic [63:0] rd_data_a, rd_data_b;
  logic [1:0]  rd_busy_a, rd_busy_b;
  logic [31:0] pend_a, pend_b;

  assign rd_addr = {a1, a0};

  always #5 clk = ~clk;

  reg_file_sb #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1), .BYPASS(1)) u_dut_byp (
    .i_clk(clk), .i_rst(i_rst), .i_rd_addr(rd_addr), .o_rd_data(rd_data_a),
    .o_rd_busy(rd_busy_a), .i_wr_en(i_wr_en), .i_wr_addr(i_wr_addr), .i_wr_data(i_wr_data),
    .i_rsv_en(i_rsv_en), .i_rsv_addr(i_rsv_addr), .o_pending(pend_a)
  );

  reg_file_sb #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1), .BYPASS(0)) u_dut_nob (
    .i_clk(clk), .i_rst(i_rst), .i_rd_addr(rd_addr), .o_rd_data(rd_data_b),
    .o_rd_busy(rd_busy_b), .i_wr_en(i_wr_en), .i_wr_addr(i_wr_addr), .i_wr_data(i_wr_data),
    .i_rsv_en(i_rsv_en), .i_rsv_addr(i_rsv_addr), .o_pending(pend_b)
  );

  typedef struct {
    int          id;
    logic [4:0]  ad0, ad1;
    logic [31:0] d0a, d1a, d0b, d1b;
    logic        b0a, b1a, b0b, b1b;
    logic [31:0] pend;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] m_mem [32];
  logic        m_pend [32];
  int          n_checks = 0;
  int          n_bad = 0;
  int          n_txn = 0;

  // Reference view of a read: register 0 is always zero; a live non-zero write
  // is seen directly when forwarding is enabled, otherwise the stored state.
  function automatic logic [31:0] ref_data(input logic [4:0] a, input bit byp);
    if (a == 5'd0) return 32'd0;
    if (byp && i_wr_en && !i_rst && i_wr_addr == a) return i_wr_data;
    return m_mem[a];
  endfunction

  function automatic logic ref_busy(input logic [4:0] a, input bit byp);
    if (a == 5'd0) return 1'b0;
    if (byp && i_wr_en && !i_rst && i_wr_addr == a) return 1'b0;
    return m_pend[a];
  endfunction

  task automatic cyc(input logic rst, input logic we, input logic [4:0] wa,
                     input logic [31:0] wd, input logic re, input logic [4:0] ra,
                     input logic [4:0] r0, input logic [4:0] r1);
    exp_t e;
    @(posedge clk);
    #1;
    i_rst = rst; i_wr_en = we; i_wr_addr = wa; i_wr_data = wd;
    i_rsv_en = re; i_rsv_addr = ra; a0 = r0; a1 = r1;
    e.id  = n_txn;
    e.ad0 = r0; e.ad1 = r1;
    e.d0a = ref_data(r0, 1'b1); e.d1a = ref_data(r1, 1'b1);
    e.d0b = ref_data(r0, 1'b0); e.d1b = ref_data(r1, 1'b0);
    e.b0a = ref_busy(r0, 1'b1); e.b1a = ref_busy(r1, 1'b1);
    e.b0b = ref_busy(r0, 1'b0); e.b1b = ref_busy(r1, 1'b0);
    for (int i = 0; i < 32; i++) e.pend[i] = m_pend[i];
    sb_q.push_back(e);
    n_txn++;
    // State seen after this edge.
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        m_mem[i] = 32'd0;
        m_pend[i] = 1'b0;
      end
    end else begin
      if (we && wa != 5'd0) begin
        m_mem[wa] = wd;
        m_pend[wa] = 1'b0;
      end
      if (re && ra != 5'd0) m_pend[ra] = 1'b1;
    end
  endtask

  task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s txn=%0d got=%h expected=%h", nm, id, act, exp);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        $display("txn %0d: a0=%0d a1=%0d byp d=%h/%h busy=%b%b nob d=%h/%h busy=%b%b pend=%h",
                 e.id, e.ad0, e.ad1, rd_data_a[31:0], rd_data_a[63:32], rd_busy_a[0], rd_busy_a[1],
                 rd_data_b[31:0], rd_data_b[63:32], rd_busy_b[0], rd_busy_b[1], pend_a);
        chk("byp_data0", e.id, rd_data_a[31:0],  e.d0a);
        chk("byp_data1", e.id, rd_data_a[63:32], e.d1a);
        chk("byp_busy0", e.id, {31'd0, rd_busy_a[0]}, {31'd0, e.b0a});
        chk("byp_busy1", e.id, {31'd0, rd_busy_a[1]}, {31'd0, e.b1a});
        chk("nob_data0", e.id, rd_data_b[31:0],  e.d0b);
        chk("nob_data1", e.id, rd_data_b[63:32], e.d1b);
        chk("nob_busy0", e.id, {31'd0, rd_busy_b[0]}, {31'd0, e.b0b});
        chk("nob_busy1", e.id, {31'd0, rd_busy_b[1]}, {31'd0, e.b1b});
        chk("byp_pending", e.id, pend_a, e.pend);
        chk("nob_pending", e.id, pend_b, e.pend);
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : driver
    for (int i = 0; i < 32; i++) begin
      m_mem[i] = 32'hX;
      m_pend[i] = 1'bX;
    end
    // Reset, then sweep every address on both ports.
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 32; i++) cyc(0, 0, 0, 0, 0, 0, 5'(i), 5'(31 - i));
    // Plain write and zero-register write.
    cyc(0, 1, 5, 32'hDEADBEEF, 0, 0, 1, 6);
    cyc(0, 0, 0, 0, 0, 0, 5, 5);
    cyc(0, 1, 0, 32'h1234, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 5);
    // Reserve r7, wait, write back with bypass observed in the same cycle.
    cyc(0, 0, 0, 0, 1, 7, 7, 0);
    cyc(0, 0, 0, 0, 0, 0, 7, 7);
    cyc(0, 0, 0, 0, 0, 0, 7, 5);
    cyc(0, 1, 7, 32'h55, 0, 0, 7, 7);
    cyc(0, 0, 0, 0, 0, 0, 7, 7);
    // Same-address write+reserve, then different-address write+reserve.
    cyc(0, 1, 9, 32'hAA, 1, 9, 9, 9);
    cyc(0, 0, 0, 0, 0, 0, 9, 0);
    cyc(0, 1, 3, 32'h33, 1, 4, 3, 4);
    cyc(0, 0, 0, 0, 0, 0, 3, 4);
    // Old-versus-new data on r2 (forwarding differs between instances).
    cyc(0, 1, 2, 32'h11, 0, 0, 0, 0);
    cyc(0, 1, 2, 32'h77, 0, 0, 2, 2);
    cyc(0, 0, 0, 0, 0, 0, 2, 2);
    // Reserve three registers, reset with strobes active, then write after reset.
    cyc(0, 0, 0, 0, 1, 1, 1, 2);
    cyc(0, 0, 0, 0, 1, 2, 1, 2);
    cyc(0, 0, 0, 0, 1, 3, 2, 3);
    cyc(1, 1, 2, 32'hBAD, 1, 5, 2, 5);
    cyc(0, 0, 0, 0, 0, 0, 1, 2);
    cyc(0, 0, 0, 0, 0, 0, 3, 9);
    cyc(0, 1, 2, 32'h9, 0, 0, 2, 1);
    cyc(0, 0, 0, 0, 0, 0, 2, 3);
    // Randomized traffic, reads biased toward the live write/reserve addresses.
    for (int n = 0; n < 400; n++) begin
      logic [4:0]  wa, ra, r0, r1;
      logic [31:0] wd;
      logic        we, re, rst;
      wa  = 5'($urandom_range(0, 31));
      ra  = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      wd  = $urandom;
      we  = 1'($urandom_range(0, 1));
      re  = 1'($urandom_range(0, 1));
      rst = ($urandom_range(0, 59) == 0);
      r0  = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31));
      r1  = ($urandom_range(0, 2) == 0) ? ra : 5'($urandom_range(0, 31));
      cyc(rst, we, wa, wd, re, ra, r0, r1);
    end
    repeat (3) @(posedge clk);
    n_checks++;
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain got=%0d expected=0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
